// File: rtl/driver_sequencer.sv
// Column/plane sequencer for a multiplexed LED driver chain: streams bit planes,
// issues WRTGS/LATGS latch pulses, blanks between columns and walks the column select.
module driver_sequencer #(
    parameter int POKER_MODE      = 9,
    parameter int BLANKING_CYCLES = 72,
    parameter int LED_PER_DRIVER  = 16,
    parameter int MUX_COUNT       = 8
) (
    input  logic                         clk_33,
    input  logic                         nrst,
    input  logic                         enable,
    output logic                         driver_ready,
    output logic                         sclk_en,
    output logic                         lat,
    output logic                         blank,
    output logic [MUX_COUNT-1:0]         mux_out,
    output logic [$clog2(MUX_COUNT)-1:0] column,
    output logic                         frame_done
);

    localparam int WORDS = 3 * LED_PER_DRIVER;
    localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PW    = (POKER_MODE > 1) ? $clog2(POKER_MODE) : 1;
    localparam int BW    = (BLANKING_CYCLES > 1) ? $clog2(BLANKING_CYCLES) : 1;
    localparam int CW    = $clog2(MUX_COUNT);

    localparam logic [WW-1:0] WORD_LAST  = WW'(WORDS - 1);
    localparam logic [WW-1:0] WORD_LATGS = WW'(WORDS - 3);
    localparam logic [PW-1:0] PLANE_LAST = PW'(POKER_MODE - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANKING_CYCLES - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(MUX_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [WW-1:0] r_word_cnt;
    logic [PW-1:0] r_plane_cnt;
    logic [BW-1:0] r_blank_cnt;
    logic [CW-1:0] r_column;
    logic          r_sclk_en;
    logic          r_lat;
    logic          r_frame_done;

    logic w_word_wrap;
    logic w_shift_end;
    logic w_blank_end;
    logic w_lat_src;

    assign w_word_wrap = (r_word_cnt == WORD_LAST);
    assign w_shift_end = (r_state == ST_SHIFT) && w_word_wrap && (r_plane_cnt == PLANE_LAST);
    assign w_blank_end = (r_state == ST_BLANK) && (r_blank_cnt == BLANK_LAST);

    // Non-final planes get a single WRTGS pulse; the final plane holds LATGS for three words.
    assign w_lat_src = (r_state == ST_SHIFT) &&
                       (((r_plane_cnt != PLANE_LAST) && w_word_wrap) ||
                        ((r_plane_cnt == PLANE_LAST) && (r_word_cnt >= WORD_LATGS)));

    // State register
    always_ff @(posedge clk_33 or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; enable is only sampled at column boundaries
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_next_state = ST_SHIFT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_shift_end) begin
                    w_next_state = ST_BLANK;
                end else begin
                    w_next_state = ST_SHIFT;
                end
            end
            ST_BLANK: begin
                if (w_blank_end) begin
                    w_next_state = enable ? ST_SHIFT : ST_IDLE;
                end else begin
                    w_next_state = ST_BLANK;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the state register
    always_comb begin
        driver_ready = 1'b0;
        blank        = 1'b0;
        mux_out      = '0;
        case (r_state)
            ST_SHIFT: begin
                driver_ready = 1'b1;
                mux_out      = MUX_COUNT'(1) << r_column;
            end
            ST_BLANK: begin
                blank = 1'b1;
            end
            default: begin
                driver_ready = 1'b0;
            end
        endcase
    end

    // Word/plane/blank counters; cleared outside their state so re-entry starts at zero
    always_ff @(posedge clk_33 or negedge nrst) begin
        if (!nrst) begin
            r_word_cnt  <= '0;
            r_plane_cnt <= '0;
            r_blank_cnt <= '0;
        end else begin
            if (r_state == ST_SHIFT) begin
                r_word_cnt <= w_word_wrap ? '0 : r_word_cnt + WW'(1);
                if (w_word_wrap) begin
                    r_plane_cnt <= (r_plane_cnt == PLANE_LAST) ? '0 : r_plane_cnt + PW'(1);
                end else begin
                    r_plane_cnt <= r_plane_cnt;
                end
            end else begin
                r_word_cnt  <= '0;
                r_plane_cnt <= '0;
            end
            if (r_state == ST_BLANK) begin
                r_blank_cnt <= w_blank_end ? '0 : r_blank_cnt + BW'(1);
            end else begin
                r_blank_cnt <= '0;
            end
        end
    end

    // Column index advances on the last blanking cycle and survives IDLE
    always_ff @(posedge clk_33 or negedge nrst) begin
        if (!nrst) begin
            r_column <= '0;
        end else if (w_blank_end) begin
            r_column <= (r_column == COL_LAST) ? '0 : r_column + CW'(1);
        end else begin
            r_column <= r_column;
        end
    end

    // One-cycle delay aligns shift clock and latch with the registered data word
    always_ff @(posedge clk_33 or negedge nrst) begin
        if (!nrst) begin
            r_sclk_en    <= 1'b0;
            r_lat        <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_sclk_en    <= (r_state == ST_SHIFT);
            r_lat        <= w_lat_src;
            r_frame_done <= w_blank_end && (r_column == COL_LAST);
        end
    end

    assign sclk_en    = r_sclk_en;
    assign lat        = r_lat;
    assign frame_done = r_frame_done;
    assign column     = r_column;

endmodule

// File: tb/tb_driver_sequencer.sv
// Directed self-checking bench for driver_sequencer: default build plus a
// reduced-parameter build (POKER_MODE=2, BLANKING_CYCLES=1, MUX_COUNT=2).
module tb_driver_sequencer;

    logic clk_33 = 1'b0;
    always #5 clk_33 = ~clk_33;

    logic nrst_a, en_a, nrst_b, en_b;
    logic dr_a, sclk_a, lat_a, blank_a, fd_a;
    logic [7:0] mux_a;
    logic [2:0] col_a;
    logic dr_b, sclk_b, lat_b, blank_b, fd_b;
    logic [1:0] mux_b;
    logic [0:0] col_b;

    driver_sequencer u_dut_a (
        .clk_33(clk_33), .nrst(nrst_a), .enable(en_a),
        .driver_ready(dr_a), .sclk_en(sclk_a), .lat(lat_a), .blank(blank_a),
        .mux_out(mux_a), .column(col_a), .frame_done(fd_a)
    );

    driver_sequencer #(
        .POKER_MODE(2), .BLANKING_CYCLES(1), .LED_PER_DRIVER(16), .MUX_COUNT(2)
    ) u_dut_b (
        .clk_33(clk_33), .nrst(nrst_b), .enable(en_b),
        .driver_ready(dr_b), .sclk_en(sclk_b), .lat(lat_b), .blank(blank_b),
        .mux_out(mux_b), .column(col_b), .frame_done(fd_b)
    );

    logic       use_small;
    logic       s_dr, s_sclk, s_lat, s_blank, s_fd;
    logic [7:0] s_mux, s_col;

    always_comb begin
        if (use_small) begin
            s_dr = dr_b; s_sclk = sclk_b; s_lat = lat_b; s_blank = blank_b; s_fd = fd_b;
            s_mux = {6'd0, mux_b}; s_col = {7'd0, col_b};
        end else begin
            s_dr = dr_a; s_sclk = sclk_a; s_lat = lat_a; s_blank = blank_a; s_fd = fd_a;
            s_mux = mux_a; s_col = {5'd0, col_a};
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // per-column statistics
    int c_cycles, c_dr, c_gap, c_bl, c_lat_hi, c_lat_pulses, c_lat_bad;
    int c_sclk_bad, c_mux_bad, c_fd, c_fd_end, c_col_end, c_mux_first;

    // Entered on the first SHIFT sample; returns on the first sample after BLANK.
    task automatic collect(input int drop_at, input int budget);
        logic prev_dr, prev_lat, seen_blank, done;
        int i;
        c_cycles = 0; c_dr = 0; c_gap = 0; c_bl = 0; c_lat_hi = 0; c_lat_pulses = 0;
        c_lat_bad = 0; c_sclk_bad = 0; c_mux_bad = 0; c_fd = 0;
        prev_dr = 1'b0; prev_lat = 1'b0; seen_blank = 1'b0; done = 1'b0; i = 0;
        c_mux_first = int'(s_mux);
        while (!done && i < budget) begin
            if (seen_blank && !s_blank) begin
                done = 1'b1;
            end else begin
                if (i == drop_at) en_a = 1'b0;
                c_cycles++;
                if (s_dr) c_dr++;
                if (s_dr && seen_blank) c_gap++;
                if (!s_dr && !s_blank) c_gap++;
                if (s_blank) begin
                    c_bl++;
                    seen_blank = 1'b1;
                    if (s_mux != 8'd0) c_mux_bad++;
                end
                if (s_lat) c_lat_hi++;
                if (s_lat && !prev_lat) c_lat_pulses++;
                if (s_lat && !s_sclk) c_lat_bad++;
                if (s_sclk != prev_dr) c_sclk_bad++;
                if (s_fd && i > 0) c_fd++;
                prev_dr = s_dr;
                prev_lat = s_lat;
                i++;
                @(negedge clk_33);
            end
        end
        check_eq("collect_timeout", int'(done), 1);
        c_fd_end = int'(s_fd);
        c_col_end = int'(s_col);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_dr"}, int'(s_dr), 0);
        check_eq({tag, "_sclk"}, int'(s_sclk), 0);
        check_eq({tag, "_lat"}, int'(s_lat), 0);
        check_eq({tag, "_blank"}, int'(s_blank), 0);
        check_eq({tag, "_mux"}, int'(s_mux), 0);
        check_eq({tag, "_fd"}, int'(s_fd), 0);
        check_eq({tag, "_col"}, int'(s_col), 0);
    endtask

    initial begin
        int frame_cycles;
        int wait_cnt;
        use_small = 1'b0;
        nrst_a = 1'b0; en_a = 1'b0; nrst_b = 1'b0; en_b = 1'b0;
        repeat (3) @(negedge clk_33);
        check_all_zero("reset");

        // released with enable low: must stay idle
        nrst_a = 1'b1;
        repeat (4) @(negedge clk_33);
        check_eq("idle_hold_dr", int'(s_dr), 0);
        check_eq("idle_hold_mux", int'(s_mux), 0);

        en_a = 1'b1;
        @(negedge clk_33);
        check_eq("first_shift_dr", int'(s_dr), 1);
        check_eq("first_shift_sclk", int'(s_sclk), 0);

        // one full frame of 8 columns
        frame_cycles = 0;
        for (int c = 0; c < 8; c++) begin
            collect(-1, 1000);
            frame_cycles += c_cycles;
            check_eq($sformatf("col%0d_mux", c), c_mux_first, 1 << c);
            check_eq($sformatf("col%0d_next", c), c_col_end, (c + 1) % 8);
            check_eq($sformatf("col%0d_frame_done", c), c_fd + c_fd_end, (c == 7) ? 1 : 0);
            check_eq($sformatf("col%0d_period", c), c_cycles, 504);
            if (c == 0) begin
                check_eq("col0_dr_cycles", c_dr, 432);
                check_eq("col0_contiguous", c_gap, 0);
                check_eq("col0_blank_cycles", c_bl, 72);
                check_eq("col0_sclk_align", c_sclk_bad, 0);
                check_eq("col0_lat_high", c_lat_hi, 11);
                check_eq("col0_lat_pulses", c_lat_pulses, 9);
                check_eq("col0_lat_vs_sclk", c_lat_bad, 0);
                check_eq("col0_blank_mux", c_mux_bad, 0);
            end
        end
        check_eq("frame_cycles", frame_cycles, 4032);

        // enable dropped at SHIFT cycle 100 of column 3
        for (int c = 0; c < 4; c++) begin
            collect((c == 3) ? 100 : -1, 1000);
            check_eq($sformatf("f2_col%0d_mux", c), c_mux_first, 1 << c);
        end
        check_eq("drop_dr_cycles", c_dr, 432);
        check_eq("drop_blank_cycles", c_bl, 72);
        check_eq("drop_column", c_col_end, 4);
        check_eq("drop_idle_dr", int'(s_dr), 0);
        check_eq("drop_idle_mux", int'(s_mux), 0);
        repeat (5) @(negedge clk_33);
        check_eq("drop_idle_hold", int'(s_dr), 0);
        check_eq("drop_idle_blank", int'(s_blank), 0);
        en_a = 1'b1;
        @(negedge clk_33);
        check_eq("resume_dr", int'(s_dr), 1);
        check_eq("resume_mux", int'(s_mux), 32'h10);

        // column 4 full, then reset in the middle of column 5 blanking
        collect(-1, 1000);
        check_eq("col4_next", c_col_end, 5);
        wait_cnt = 0;
        while (!s_blank && wait_cnt < 600) begin
            @(negedge clk_33);
            wait_cnt++;
        end
        check_eq("col5_reached_blank", int'(s_blank), 1);
        repeat (10) @(negedge clk_33);
        #2 nrst_a = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk_33);
        nrst_a = 1'b1;
        @(negedge clk_33);
        check_eq("post_reset_dr", int'(s_dr), 1);
        check_eq("post_reset_col", int'(s_col), 0);
        check_eq("post_reset_mux", int'(s_mux), 1);

        // reduced-parameter instance
        use_small = 1'b1;
        @(negedge clk_33);
        nrst_b = 1'b1; en_b = 1'b1;
        @(negedge clk_33);
        check_eq("small_first_dr", int'(s_dr), 1);
        collect(-1, 300);
        frame_cycles = c_cycles;
        check_eq("small_period", c_cycles, 97);
        check_eq("small_dr_cycles", c_dr, 96);
        check_eq("small_blank_cycles", c_bl, 1);
        check_eq("small_lat_high", c_lat_hi, 4);
        check_eq("small_lat_pulses", c_lat_pulses, 2);
        check_eq("small_col_next", c_col_end, 1);
        check_eq("small_fd_early", c_fd + c_fd_end, 0);
        collect(-1, 300);
        frame_cycles += c_cycles;
        check_eq("small_col1_mux", c_mux_first, 2);
        check_eq("small_wrap_col", c_col_end, 0);
        check_eq("small_frame_done", c_fd + c_fd_end, 1);
        check_eq("small_frame_cycles", frame_cycles, 194);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/driver_sequencer.md
DRIVER_SEQUENCER -- requirements
Module: driver_sequencer

Interface
REQ-001 The block SHALL have parameter POKER_MODE, default 9, meaning bit planes per column.
REQ-002 The block SHALL have parameter BLANKING_CYCLES, default 72, meaning blank cycles per column.
REQ-003 The block SHALL have parameter LED_PER_DRIVER, default 16, meaning LEDs per driver.
REQ-004 The block SHALL have parameter MUX_COUNT, default 8, meaning multiplexed columns.
REQ-005 The block SHALL have port clk_33, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port nrst, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port enable, input, 1 bit: run request, level-sensitive.
REQ-008 The block SHALL have port driver_ready, output, 1 bit: advance the framebuffer data stream this cycle.
REQ-009 The block SHALL have port sclk_en, output, 1 bit: driver shift clock gate, aligned with the registered data word.
REQ-010 The block SHALL have port lat, output, 1 bit: driver latch, aligned with sclk_en.
REQ-011 The block SHALL have port blank, output, 1 bit: high during BLANK state.
REQ-012 The block SHALL have port mux_out, output, MUX_COUNT bits: one-hot column select.
REQ-013 The block SHALL have port column, output, $clog2(MUX_COUNT) bits: current column index.
REQ-014 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at column wrap.

Function
REQ-015 The block SHALL implement FSM states IDLE, SHIFT, BLANK.
REQ-016 IDLE SHALL go to SHIFT on the clock edge where enable=1; otherwise it SHALL stay in IDLE.
REQ-017 driver_ready SHALL be 1 exactly while the FSM is in SHIFT (Moore output); the first SHIFT cycle SHALL be the cycle after enable is sampled.
REQ-018 word_cnt SHALL count 0..3*LED_PER_DRIVER-1 (0..47) in SHIFT, and plane_cnt SHALL count 0..POKER_MODE-1, incrementing when word_cnt wraps.
REQ-019 SHIFT SHALL go to BLANK after the cycle with word_cnt=47 and plane_cnt=POKER_MODE-1, i.e. 432 SHIFT cycles at defaults.
REQ-020 sclk_en SHALL equal driver_ready delayed by exactly 1 cycle.
REQ-021 lat SHALL be delayed by 1 cycle from its source condition, the same as sclk_en.
REQ-022 lat source, non-final plane: a 1-cycle pulse on word_cnt=47 (WRTGS).
REQ-023 lat source, final plane: high on word_cnt 45..47 (LATGS, 3 cycles).
REQ-024 BLANK SHALL last exactly BLANKING_CYCLES cycles with blank=1, driver_ready=0, mux_out=0.
REQ-025 On the last BLANK cycle, column SHALL increment modulo MUX_COUNT (7 wraps to 0).
REQ-026 frame_done SHALL pulse for 1 cycle on the 7 to 0 column wrap.
REQ-027 From BLANK, the next state SHALL be SHIFT if enable=1 on the last BLANK cycle, else IDLE.
REQ-028 A column period SHALL be 504 cycles at defaults, and a frame SHALL be 4032 cycles.
REQ-029 enable deasserted mid-SHIFT or mid-BLANK SHALL be ignored until the current column completes; there SHALL be no partial columns.
REQ-030 Re-entry from IDLE SHALL resume at the stored column with word_cnt=plane_cnt=0.
REQ-031 mux_out SHALL be one-hot(column) in SHIFT, and 0 in IDLE and BLANK.
REQ-032 All counters SHALL be sized by $clog2 of their parameter bounds, with no overflow beyond the stated ranges.

Reset
REQ-033 When nrst=0, the block SHALL asynchronously force: state=IDLE, word_cnt=0, plane_cnt=0, column=0, driver_ready=0, sclk_en=0, lat=0, blank=0, mux_out=0, frame_done=0.
REQ-034 Reset asserted mid-operation SHALL abort immediately; after release the FSM SHALL wait in IDLE for enable.
REQ-035 Reset deassertion SHALL be synchronised externally; the block SHALL impose no internal reset synchroniser.

Verification
REQ-036 Bench: enable=1 from reset -> driver_ready high for 432 contiguous cycles, sclk_en identical shifted +1, then blank=1 for 72 cycles, column 0 to 1.
REQ-037 Bench: count lat pulses over one column -> 8 single-cycle pulses at plane ends, then one 3-cycle pulse; total 11 lat-high cycles, each coincident with sclk_en=1.
REQ-038 Bench: run 8 columns -> frame_done exactly once, at 0 to 7 to 0 wrap, 4032 cycles after first driver_ready; mux_out walks 0x01 to 0x80.
REQ-039 Bench: drop enable at SHIFT cycle 100 of column 3 -> column completes (332 more SHIFT + 72 BLANK), column=4, IDLE; re-raise -> SHIFT next cycle, mux_out=0x10.
REQ-040 Bench: assert nrst=0 mid-BLANK of column 5 -> all outputs 0 in the same cycle (asynchronous); after release and enable -> column=0.
REQ-041 Bench: parameters POKER_MODE=2, BLANKING_CYCLES=1, MUX_COUNT=2 -> column period 97 cycles, frame 194 cycles, lat-high cycles per column = 1+3.
